// File: rtl/poci_if.sv
// POCI (APB-style) bus bundle shared by the upstream master port and the
// exported downstream slave port.
//
// Handshake: a transfer is one setup cycle (psel=1, penable=0) followed by
// exactly one access cycle (psel=1, penable=1). The access completes in the
// cycle where pready=1. This subsystem never inserts wait states, so pready
// is tied high. prdata is only meaningful while psel=1.
interface poci_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;

    // Bus driver side (the downstream port has no pready of its own)
    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata
    );

    // Bus responder side
    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/poci_keys_subsystem.sv
// POCI peripheral subsystem: address decode, an internal read-only
// key/switch slave (slave 0), and a zero-latency pass-through of the
// LED/hex region (slave 1) onto a downstream POCI port.
module poci_keys_subsystem #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    KEY_WIDTH   = 4,
    parameter int                    SW_WIDTH    = 10,
    parameter logic [ADDR_WIDTH-1:0] PERIPH_BASE = 32'h4000_0000
) (
    input  logic                 pclk,
    input  logic                 preset,
    poci_if.slave                m,
    poci_if.master               s1,
    input  logic [KEY_WIDTH-1:0] key,
    input  logic [SW_WIDTH-1:0]  sw
);

    // Two-flop synchronisers for the asynchronous board inputs
    logic [KEY_WIDTH-1:0] r_key_meta;
    logic [KEY_WIDTH-1:0] r_key_s;
    logic [SW_WIDTH-1:0]  r_sw_meta;
    logic [SW_WIDTH-1:0]  r_sw_s;

    // Decode signals
    logic                  w_region_valid;
    logic                  w_sel0;
    logic                  w_sel1;
    logic [9:0]            w_offset;
    logic [DATA_WIDTH-1:0] w_keys_rdata;
    logic [DATA_WIDTH-1:0] w_prdata;

    // Synchronise key and switch inputs; reset clears both stages
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_key_meta <= '0;
            r_key_s    <= '0;
            r_sw_meta  <= '0;
            r_sw_s     <= '0;
        end else begin
            r_key_meta <= key;
            r_key_s    <= r_key_meta;
            r_sw_meta  <= sw;
            r_sw_s     <= r_sw_meta;
        end
    end

    // Nothing below the peripheral base is decoded; bit 12 splits the slaves
    assign w_region_valid = (m.paddr >= PERIPH_BASE);
    assign w_sel0         = m.psel & w_region_valid & ~m.paddr[12];
    assign w_sel1         = m.psel & w_region_valid &  m.paddr[12];
    assign w_offset       = m.paddr[11:2];

    // Key slave read data straight from the address; writes have no effect
    always_comb begin
        w_keys_rdata = '0;
        if (w_offset == 10'd0) begin
            w_keys_rdata[KEY_WIDTH-1:0] = r_key_s;
        end else if (w_offset == 10'd1) begin
            w_keys_rdata[SW_WIDTH-1:0] = r_sw_s;
        end
    end

    // Return-data mux back to the master; zero when nothing is selected
    always_comb begin
        w_prdata = '0;
        if (w_sel1) begin
            w_prdata = s1.prdata;
        end else if (w_sel0) begin
            w_prdata = w_keys_rdata;
        end
    end

    assign m.prdata = w_prdata;
    assign m.pready = 1'b1;

    // Downstream port follows the master with no added latency
    assign s1.paddr   = m.paddr;
    assign s1.pwrite  = m.pwrite;
    assign s1.pwdata  = m.pwdata;
    assign s1.psel    = w_sel1;
    assign s1.penable = m.penable & w_sel1;

endmodule

// File: tb/tb_poci_keys_subsystem.sv
// Directed bench for poci_keys_subsystem. Inputs change 1 time unit after a
// rising edge; outputs are sampled on the falling edge.
module tb_poci_keys_subsystem;

    logic       pclk;
    logic       preset;
    logic [3:0] key;
    logic [9:0] sw;

    int n_cmp;
    int n_fail;

    poci_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();
    poci_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s1_if ();

    poci_keys_subsystem dut (
        .pclk   (pclk),
        .preset (preset),
        .m      (m_if),
        .s1     (s1_if),
        .key    (key),
        .sw     (sw)
    );

    // Clock
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Driver tasks: each waits for a rising edge then drives 1 unit later
    task automatic drive_setup(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
        @(posedge pclk);
        #1;
        m_if.paddr   = addr;
        m_if.pwrite  = wr;
        m_if.pwdata  = wd;
        m_if.psel    = 1'b1;
        m_if.penable = 1'b0;
    endtask

    task automatic drive_access();
        @(posedge pclk);
        #1;
        m_if.penable = 1'b1;
    endtask

    task automatic drive_idle();
        @(posedge pclk);
        #1;
        m_if.psel    = 1'b0;
        m_if.penable = 1'b0;
        m_if.pwrite  = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        key    = 4'hF;
        sw     = 10'h3FF;
        repeat (2) @(posedge pclk);
        #1;
        preset       = 1'b0;
        m_if.paddr   = 32'h4000_0000;
        m_if.pwrite  = 1'b0;
        m_if.psel    = 1'b1;
        m_if.penable = 1'b0;
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0) begin
            $display("FAIL reset_key_setup: got %h want %h", m_if.prdata, 32'h0);
            n_fail++;
        end
        n_cmp++;
        if (m_if.pready !== 1'b1) begin
            $display("FAIL reset_pready: got %b want 1", m_if.pready);
            n_fail++;
        end
        n_cmp++;
        if (s1_if.psel !== 1'b0) begin
            $display("FAIL reset_s1_psel: got %b want 0", s1_if.psel);
            n_fail++;
        end
        drive_access();
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0) begin
            $display("FAIL reset_key_one_edge: got %h want %h", m_if.prdata, 32'h0);
            n_fail++;
        end
        drive_setup(32'h4000_0000, 1'b0, 32'h0);
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_000F) begin
            $display("FAIL reset_key_two_edges: got %h want %h", m_if.prdata, 32'h0000_000F);
            n_fail++;
        end
        drive_access();
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_000F) begin
            $display("FAIL reset_key_access: got %h want %h", m_if.prdata, 32'h0000_000F);
            n_fail++;
        end
        drive_idle();
    endtask

    task automatic test_key_sw();
        key = 4'hA;
        sw  = 10'h2B5;
        repeat (3) drive_idle();
        drive_setup(32'h4000_0000, 1'b0, 32'h0);
        drive_access();
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_000A) begin
            $display("FAIL key_read_A: got %h want %h", m_if.prdata, 32'h0000_000A);
            n_fail++;
        end
        drive_setup(32'h4000_0004, 1'b0, 32'h0);
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_02B5) begin
            $display("FAIL sw_read_setup: got %h want %h", m_if.prdata, 32'h0000_02B5);
            n_fail++;
        end
        drive_access();
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_02B5) begin
            $display("FAIL sw_read_access: got %h want %h", m_if.prdata, 32'h0000_02B5);
            n_fail++;
        end
        drive_idle();
    endtask

    task automatic test_sync_latency();
        @(posedge pclk);
        #1;
        key = 4'h5;
        m_if.paddr   = 32'h4000_0000;
        m_if.pwrite  = 1'b0;
        m_if.psel    = 1'b1;
        m_if.penable = 1'b0;
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_000A) begin
            $display("FAIL latency_zero_edges: got %h want %h", m_if.prdata, 32'h0000_000A);
            n_fail++;
        end
        drive_access();
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_000A) begin
            $display("FAIL latency_one_edge: got %h want %h", m_if.prdata, 32'h0000_000A);
            n_fail++;
        end
        drive_setup(32'h4000_0000, 1'b0, 32'h0);
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_0005) begin
            $display("FAIL latency_two_edges: got %h want %h", m_if.prdata, 32'h0000_0005);
            n_fail++;
        end
        drive_access();
        drive_idle();
    endtask

    task automatic test_s1_write();
        drive_setup(32'h4000_1004, 1'b1, 32'h1234_5678);
        @(negedge pclk);
        n_cmp++;
        if (s1_if.psel !== 1'b1 || s1_if.penable !== 1'b0) begin
            $display("FAIL s1_wr_setup_sel_en: got %b%b want 10", s1_if.psel, s1_if.penable);
            n_fail++;
        end
        n_cmp++;
        if (s1_if.pwdata !== 32'h1234_5678 || s1_if.pwrite !== 1'b1 || s1_if.paddr !== 32'h4000_1004) begin
            $display("FAIL s1_wr_fields: got %h %b %h want 12345678 1 40001004",
                     s1_if.pwdata, s1_if.pwrite, s1_if.paddr);
            n_fail++;
        end
        drive_access();
        @(negedge pclk);
        n_cmp++;
        if (s1_if.psel !== 1'b1 || s1_if.penable !== 1'b1) begin
            $display("FAIL s1_wr_access_sel_en: got %b%b want 11", s1_if.psel, s1_if.penable);
            n_fail++;
        end
        drive_idle();
        @(negedge pclk);
        n_cmp++;
        if (s1_if.psel !== 1'b0 || s1_if.penable !== 1'b0) begin
            $display("FAIL s1_idle_sel_en: got %b%b want 00", s1_if.psel, s1_if.penable);
            n_fail++;
        end
        drive_setup(32'h4000_0000, 1'b0, 32'h0);
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_0005) begin
            $display("FAIL key_after_s1_write: got %h want %h", m_if.prdata, 32'h0000_0005);
            n_fail++;
        end
        drive_access();
        drive_idle();
    endtask

    task automatic test_s1_read();
        s1_if.prdata = 32'h0000_03C5;
        drive_setup(32'h4000_1008, 1'b0, 32'h0);
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_03C5 || s1_if.psel !== 1'b1) begin
            $display("FAIL s1_rd_setup: got %h sel %b want 000003c5 sel 1", m_if.prdata, s1_if.psel);
            n_fail++;
        end
        drive_access();
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_03C5 || s1_if.penable !== 1'b1) begin
            $display("FAIL s1_rd_access: got %h en %b want 000003c5 en 1", m_if.prdata, s1_if.penable);
            n_fail++;
        end
        drive_idle();
        m_if.paddr = 32'h4000_1008;
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0 || s1_if.psel !== 1'b0) begin
            $display("FAIL s1_rd_no_psel: got %h sel %b want 00000000 sel 0", m_if.prdata, s1_if.psel);
            n_fail++;
        end
    endtask

    task automatic test_out_of_range();
        drive_setup(32'h3FFF_FFFC, 1'b0, 32'h0);
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0 || s1_if.psel !== 1'b0) begin
            $display("FAIL below_base: got %h sel %b want 00000000 sel 0", m_if.prdata, s1_if.psel);
            n_fail++;
        end
        drive_access();
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0 || s1_if.penable !== 1'b0) begin
            $display("FAIL below_base_access: got %h en %b want 00000000 en 0", m_if.prdata, s1_if.penable);
            n_fail++;
        end
        drive_setup(32'h4000_0008, 1'b0, 32'h0);
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0 || s1_if.psel !== 1'b0) begin
            $display("FAIL unmapped_offset: got %h sel %b want 00000000 sel 0", m_if.prdata, s1_if.psel);
            n_fail++;
        end
        drive_access();
        drive_idle();
    endtask

    task automatic test_key_write_ignored();
        drive_setup(32'h4000_0000, 1'b1, 32'hFFFF_FFFF);
        @(negedge pclk);
        n_cmp++;
        if (m_if.pready !== 1'b1 || s1_if.psel !== 1'b0) begin
            $display("FAIL key_wr_setup: got rdy %b sel %b want rdy 1 sel 0", m_if.pready, s1_if.psel);
            n_fail++;
        end
        drive_access();
        @(negedge pclk);
        n_cmp++;
        if (m_if.pready !== 1'b1) begin
            $display("FAIL key_wr_access_pready: got %b want 1", m_if.pready);
            n_fail++;
        end
        drive_idle();
        drive_setup(32'h4000_0000, 1'b0, 32'h0);
        drive_access();
        @(negedge pclk);
        n_cmp++;
        if (m_if.prdata !== 32'h0000_0005) begin
            $display("FAIL key_after_write: got %h want %h", m_if.prdata, 32'h0000_0005);
            n_fail++;
        end
        drive_idle();
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        m_if.paddr   = '0;
        m_if.pwrite  = 1'b0;
        m_if.psel    = 1'b0;
        m_if.penable = 1'b0;
        m_if.pwdata  = '0;
        s1_if.prdata = '0;
        s1_if.pready = 1'b1;
        preset       = 1'b1;
        key          = '0;
        sw           = '0;

        test_reset();
        test_key_sw();
        test_sync_latency();
        test_s1_write();
        test_s1_read();
        test_out_of_range();
        test_key_write_ignored();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/poci_keys_subsystem.md
Name: poci_keys_subsystem

Overview:
- POCI (APB-style) peripheral subsystem: one master port, an address decoder, and an internal key/switch input slave.
- Slave 0 is the internal key/switch slave; slave 1 is exported on a downstream POCI port (LED/hex driver region).
- Sits between the CPU-side POCI master and board peripherals; synchronises pushbutton and toggle-switch inputs for read-back.

Parameters:
- ADDR_WIDTH, 32, POCI address width
- DATA_WIDTH, 32, POCI data width
- KEY_WIDTH, 4, number of pushbuttons
- SW_WIDTH, 10, number of toggle switches
- PERIPH_BASE, 32'h4000_0000, lowest peripheral address; psel is only honoured at or above it

Ports:
- pclk  in  1  clock; all state on rising edge
- preset  in  1  synchronous, active-high reset
- m_paddr  in  ADDR_WIDTH  master address
- m_pwrite  in  1  1 = write, 0 = read
- m_psel  in  1  master select
- m_penable  in  1  access phase
- m_pwdata  in  DATA_WIDTH  write data
- m_prdata  out  DATA_WIDTH  read data to master
- m_pready  out  1  always 1 (no wait states)
- s1_paddr  out  ADDR_WIDTH  exported slave address
- s1_pwrite  out  1  exported write strobe
- s1_psel  out  1  exported select
- s1_penable  out  1  exported enable
- s1_pwdata  out  DATA_WIDTH  exported write data
- s1_prdata  in  DATA_WIDTH  exported slave read data
- key  in  KEY_WIDTH  raw pushbuttons (asynchronous)
- sw  in  SW_WIDTH  raw toggle switches (asynchronous)

Behaviour:
- Address map:
  - KEY = 0x4000_0000
  - SW = 0x4000_0004
  - Slave 1 window = 0x4000_1000–0x4000_1FFF (HEX 0x4000_1000, LEDG 0x4000_1004, LEDR 0x4000_1008)
- Decode, combinational:
  - Region valid when m_paddr >= PERIPH_BASE.
  - sel0 = m_psel & valid & (m_paddr[12] == 0).
  - sel1 = m_psel & valid & (m_paddr[12] == 1).
- Slave 1 pass-through, combinational, zero latency:
  - s1_paddr, s1_pwrite, s1_pwdata = master values.
  - s1_psel = sel1; s1_penable = m_penable & sel1.
- m_prdata, combinational:
  - s1_prdata when sel1.
  - Keys read data when sel0.
  - 0 otherwise, including m_psel = 0.
- m_pready = 1 constant. Every transfer is setup phase (psel=1, penable=0) followed by exactly one access phase (penable=1).
- Keys slave:
  - key and sw each pass through a two-flop synchroniser; synchronised values are key_s and sw_s.
  - Read KEY returns {zeros, key_s}, i.e. {28'b0, key_s}.
  - Read SW returns {zeros, sw_s}, i.e. {22'b0, sw_s}.
  - Read data at word offset[11:2] other than 0 or 1 returns 0.
  - Read data is valid in both setup and access phases (combinational from paddr).
  - Writes to the keys slave are ignored; no side effects.
- Input latency: a change on key/sw is visible in m_prdata after the 2nd rising pclk following the change. A read whose access phase starts ≥2 edges after the change returns the new value.
- Reset: while preset = 1 at a rising edge, synchroniser flops clear to 0. Immediately after reset, KEY/SW reads return 0 until inputs propagate (2 edges).
- Reset mid-transfer: no transfer state is held, so the decode remains combinational. Only synchroniser contents are cleared.
- Transfers below PERIPH_BASE: no slave selected, m_prdata = 0, writes dropped.

Test Plan:
- Reset held 2 cycles with key=4'hF, sw=10'h3FF → read of 0x4000_0000 in the first post-reset cycle returns 0. After 2 further edges it returns 0x0000_000F.
- key=4'hA set async, 2+ cycles later read 0x4000_0000 → m_prdata = 0x0000_000A in the access phase. sw=10'h2B5, read 0x4000_0004 → 0x0000_02B5.
- Write 0x1234_5678 to 0x4000_1004 → s1_psel=1 in both phases, s1_penable=1 only in access, s1_pwdata=0x1234_5678, s1_pwrite=1. No change to keys reads.
- Read 0x4000_1008 with s1_prdata=0x0000_03C5 → m_prdata = 0x0000_03C5. Same read with m_psel=0 → s1_psel=0, m_prdata=0.
- Read 0x3FFF_FFFC and 0x4000_0008 → m_prdata = 0; s1_psel stays 0 for both.
- Write 0xFFFF_FFFF to 0x4000_0000 → subsequent KEY read still returns synchronised key value; m_pready = 1 throughout.
